// File: rtl/mem_rdata_demux.sv
// mem_rdata_demux: phase generator and tagged return-data steering for a shared single-port memory
module mem_rdata_demux #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         req_valid,
  input  logic [N-1:0] mem_rdata,
  output logic         phase,
  output logic [N-1:0] inst_out,
  output logic         inst_valid,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  output logic         busy
);
  logic tag_valid, tag_phase, cap_inst, cap_data;
  assign cap_inst = tag_valid & ~tag_phase & ~flush;
  assign cap_data = tag_valid & tag_phase;
  assign busy = tag_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= 1'b0;
      tag_valid  <= 1'b0;
      tag_phase  <= 1'b0;
      inst_out   <= '0;
      data_out   <= '0;
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      phase      <= stall ? phase : ~phase;
      tag_valid  <= req_valid & ~stall;
      tag_phase  <= phase;
      inst_valid <= cap_inst;
      data_valid <= cap_data;
      if (cap_inst) inst_out <= mem_rdata;
      if (cap_data) data_out <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_rdata_demux.sv
// tb_mem_rdata_demux: randomized and directed checks against a queue-based return-path model
module tb_mem_rdata_demux;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, stall = 1'b0, flush = 1'b0, req_valid = 1'b0;
  logic [31:0] mem_rdata = '0, inst_out, data_out;
  logic phase, inst_valid, data_valid, busy;
  logic rst16 = 1'b1, req16 = 1'b0;
  logic [15:0] rdata16 = '0, inst16, data16;
  logic phase16, iv16, dv16, busy16;
  mem_rdata_demux dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .req_valid(req_valid),
    .mem_rdata(mem_rdata), .phase(phase), .inst_out(inst_out), .inst_valid(inst_valid),
    .data_out(data_out), .data_valid(data_valid), .busy(busy)
  );
  mem_rdata_demux #(.N(16)) dut16 (
    .clk(clk), .rst(rst16), .stall(1'b0), .flush(1'b0), .req_valid(req16),
    .mem_rdata(rdata16), .phase(phase16), .inst_out(inst16), .inst_valid(iv16),
    .data_out(data16), .data_valid(dv16), .busy(busy16)
  );
  typedef struct {logic kind; int due;} pend_t;
  pend_t q[$];
  int cyc = 0, n_checks = 0, n_fail = 0;
  logic m_phase = 1'b0, m_iv = 1'b0, m_dv = 1'b0;
  logic [31:0] m_inst = '0, m_data = '0;
  function automatic string got_s();
    return $sformatf("got ph=%b iv=%b dv=%b busy=%b inst=%h data=%h", phase, inst_valid, data_valid, busy, inst_out, data_out);
  endfunction
  function automatic string want_s();
    return $sformatf("want ph=%b iv=%b dv=%b busy=%b inst=%h data=%h", m_phase, m_iv, m_dv, q.size() != 0, m_inst, m_data);
  endfunction
  // Each pending read is a queue entry tagged with its slot kind and the cycle its data returns.
  task automatic cycle(input logic r, input logic s, input logic f, input logic v, input logic [31:0] d);
    rst = r; stall = s; flush = f; req_valid = v; mem_rdata = d;
    @(posedge clk);
    if (r) begin
      q.delete(); m_phase = 0; m_iv = 0; m_dv = 0; m_inst = 0; m_data = 0;
    end else begin
      m_iv = 0; m_dv = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        pend_t p;
        p = q.pop_front();
        if (!p.kind && !f) begin m_inst = d; m_iv = 1; end
        if (p.kind) begin m_data = d; m_dv = 1; end
      end
      if (v && !s) q.push_back('{kind: m_phase, due: cyc + 1});
      if (!s) m_phase = ~m_phase;
    end
    cyc++;
    #1;
  endtask
  task automatic test_reset();
    cycle(1, 0, 0, 1, 32'hFFFFFFFF);
    cycle(1, 1, 1, 1, 32'hFFFFFFFF);
    n_checks++;
    if ({phase, inst_valid, data_valid, busy, inst_out, data_out} !== {1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL reset: %s, want all zero", got_s());
    end
  endtask
  task automatic test_free_run();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 1, m_phase ? 32'h00000013 : 32'hDEADBEEF);
      n_checks++;
      if ({phase, inst_valid, data_valid, busy, inst_out, data_out} !== {m_phase, m_iv, m_dv, q.size() != 0, m_inst, m_data}) begin
        n_fail++; $display("FAIL free_run cyc%0d: %s, %s", cyc, got_s(), want_s());
      end
      n_checks++;
      if (phase !== i[0] ^ 1'b1 || inst_valid !== (i % 2 == 1) || data_valid !== (i % 2 == 0 && i > 0)) begin
        n_fail++; $display("FAIL free_run_pattern i=%0d: got ph=%b iv=%b dv=%b", i, phase, inst_valid, data_valid);
      end
    end
    n_checks++;
    if (inst_out !== 32'h00000013 || data_out !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL free_run_values: got inst=%h data=%h, want 00000013 deadbeef", inst_out, data_out);
    end
  endtask
  task automatic test_idle();
    while (m_phase != 1'b1) cycle(0, 0, 0, 1, 32'hDEADBEEF);
    cycle(0, 0, 0, 0, 32'h00000013);
    cycle(0, 0, 0, 0, 32'hFFFFFFFF);
    n_checks++;
    if ({phase, inst_valid, data_valid, busy, inst_out, data_out} !== {m_phase, m_iv, m_dv, q.size() != 0, m_inst, m_data}) begin
      n_fail++; $display("FAIL idle_model: %s, %s", got_s(), want_s());
    end
    n_checks++;
    if (data_valid !== 1'b0 || data_out !== 32'hDEADBEEF || phase !== 1'b1) begin
      n_fail++; $display("FAIL idle_slot: got dv=%b data=%h ph=%b, want 0 deadbeef 1", data_valid, data_out, phase);
    end
  endtask
  task automatic test_flush();
    while (m_phase != 1'b0) cycle(0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 1, 32'h0);
    cycle(0, 0, 1, 1, 32'h12345678);
    n_checks++;
    if (inst_valid !== 1'b0 || inst_out !== 32'h00000013 || phase !== 1'b0) begin
      n_fail++; $display("FAIL flush_inst: got iv=%b inst=%h ph=%b, want 0 00000013 0", inst_valid, inst_out, phase);
    end
    cycle(0, 0, 1, 0, 32'hBEEF0001);
    n_checks++;
    if (data_valid !== 1'b1 || data_out !== 32'hBEEF0001 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_data: got dv=%b data=%h iv=%b, want 1 beef0001 0", data_valid, data_out, inst_valid);
    end
  endtask
  task automatic test_stall();
    while (m_phase != 1'b1) cycle(0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 1, i == 0 ? 32'hCAFEF00D : $urandom);
      n_checks++;
      if (phase !== 1'b0 || data_valid !== (i == 0) || inst_valid !== 1'b0 || data_out !== 32'hCAFEF00D || busy !== 1'b0) begin
        n_fail++; $display("FAIL stall_%0d: got ph=%b dv=%b iv=%b data=%h busy=%b", i, phase, data_valid, inst_valid, data_out, busy);
      end
    end
    cycle(0, 0, 0, 0, 32'h0);
    n_checks++;
    if ({phase, inst_valid, data_valid, busy, inst_out, data_out} !== {m_phase, m_iv, m_dv, q.size() != 0, m_inst, m_data} || phase !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: %s, %s", got_s(), want_s());
    end
  endtask
  task automatic test_reset_inflight();
    while (m_phase != 1'b0) cycle(0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 1, 32'h0);
    cycle(1, 0, 0, 1, 32'h55555555);
    n_checks++;
    if ({phase, inst_valid, data_valid, busy, inst_out, data_out} !== {1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL reset_inflight: %s, want all zero", got_s());
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, $urandom);
      n_checks++;
      if (inst_valid !== 1'b0 || inst_out !== 32'h0) begin
        n_fail++; $display("FAIL reset_dropped_%0d: got iv=%b inst=%h, want 0 0", i, inst_valid, inst_out);
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom % 40 == 0, $urandom % 4 == 0, $urandom % 4 == 0, $urandom % 4 != 0, $urandom);
      n_checks++;
      if ({phase, inst_valid, data_valid, busy, inst_out, data_out} !== {m_phase, m_iv, m_dv, q.size() != 0, m_inst, m_data}) begin
        n_fail++; $display("FAIL random cyc%0d: %s, %s", cyc, got_s(), want_s());
      end
      n_checks++;
      if (inst_valid && data_valid) begin
        n_fail++; $display("FAIL random_overlap cyc%0d: got iv=1 dv=1, want not both", cyc);
      end
    end
  endtask
  task automatic test_width();
    rst16 = 1; @(posedge clk); #1;
    rst16 = 0; req16 = 1; @(posedge clk); #1;
    req16 = 0; rdata16 = 16'hA5A5; @(posedge clk); #1;
    n_checks++;
    if (inst16 !== 16'hA5A5 || iv16 !== 1'b1 || dv16 !== 1'b0 || phase16 !== 1'b0) begin
      n_fail++; $display("FAIL width16: got inst=%h iv=%b dv=%b ph=%b, want a5a5 1 0 0", inst16, iv16, dv16, phase16);
    end
  endtask
  initial begin
    test_reset();
    test_free_run();
    test_idle();
    test_flush();
    test_stall();
    test_reset_inflight();
    test_random();
    test_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
